// File: rtl/ui_device_controller_pkg.sv
// ui_device_controller_pkg: UI device select codes and the seven-segment glyph table.
package ui_device_controller_pkg;
  localparam logic [1:0] UI_HEX  = 2'd0;
  localparam logic [1:0] UI_LEDR = 2'd1;
  localparam logic [1:0] UI_KEY  = 2'd2;
  localparam logic [1:0] UI_SW   = 2'd3;

  // Active-low segments {g,f,e,d,c,b,a}, hex glyphs 0-F
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/ui_device_controller_seven_seg_decoder.sv
// seven_seg_decoder: one hex nibble to an active-low seven-segment glyph.
module seven_seg_decoder
  import ui_device_controller_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = seg7(i_nib);
endmodule

// File: rtl/ui_device_controller.sv
// ui_device_controller: HEX/LEDR output registers, KEY/SW sync + debounce, read mux.
// Optional `define UI_KEY_STICKY_EN makes KEY reads return sticky press flags (read or W1C clears).
module ui_device_controller
  import ui_device_controller_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int KEYBITS         = 4,
  parameter int SWBITS          = 10,
  parameter int LEDRBITS        = 10,
  parameter int HEXDIGITS       = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             uiDevice,
  input  logic                   uiWrtEn,
  input  logic                   uiRdEn,
  input  logic [DBITS-1:0]       dataIn,
  output logic [DBITS-1:0]       dataOut,
  input  logic [KEYBITS-1:0]     KEY,
  input  logic [SWBITS-1:0]      SW,
  output logic [LEDRBITS-1:0]    LEDR,
  output logic [7*HEXDIGITS-1:0] HEX
);
  localparam int NB = KEYBITS + SWBITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [4*HEXDIGITS-1:0] r_hex;
  logic [LEDRBITS-1:0]    r_ledr;
  logic [NB-1:0]          w_pin, w_deb, w_acc;
  logic [KEYBITS-1:0]     w_key_deb, w_key_rd;
  logic [SWBITS-1:0]      w_sw_deb;
  logic                   w_unused;

  // KEY inverted up front so a debounced 1 means pressed
  assign w_pin     = {SW, ~KEY};
  assign w_key_deb = w_deb[KEYBITS-1:0];
  assign w_sw_deb  = w_deb[NB-1:KEYBITS];
  assign w_unused  = ^{dataIn, uiRdEn};

  for (genvar g = 0; g < NB; g++) begin : g_in
    logic          r_s1, r_s2, r_deb;
    logic [CW-1:0] r_cnt;
    assign w_acc[g] = (r_s2 != r_deb) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_deb[g] = r_deb;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_deb <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_pin[g];
        r_s2 <= r_s1;
        if (r_s2 == r_deb) r_cnt <= '0;
        else if (w_acc[g]) begin
          r_deb <= r_s2;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex  <= '0;
      r_ledr <= '0;
    end else begin
      if (uiWrtEn && uiDevice == UI_HEX)  r_hex  <= dataIn[4*HEXDIGITS-1:0];
      if (uiWrtEn && uiDevice == UI_LEDR) r_ledr <= dataIn[LEDRBITS-1:0];
    end
  end

`ifdef UI_KEY_STICKY_EN
  logic [KEYBITS-1:0] r_key_pend, w_key_clr;
  assign w_key_clr = {KEYBITS{uiRdEn && uiDevice == UI_KEY}} |
                     ((uiWrtEn && uiDevice == UI_KEY) ? dataIn[KEYBITS-1:0] : '0);
  // A press accepted this cycle sets its flag even if a clear lands on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_key_pend <= '0;
    else r_key_pend <= (r_key_pend & ~w_key_clr) | (w_acc[KEYBITS-1:0] & ~w_key_deb);
  end
  assign w_key_rd = r_key_pend;
`else
  assign w_key_rd = w_key_deb;
`endif

  always_comb begin
    dataOut = (uiDevice == UI_HEX)  ? DBITS'(r_hex)    :
              (uiDevice == UI_LEDR) ? DBITS'(r_ledr)   :
              (uiDevice == UI_KEY)  ? DBITS'(w_key_rd) :
              (uiDevice == UI_SW)   ? DBITS'(w_sw_deb) : '0;
  end

  assign LEDR = r_ledr;

  for (genvar d = 0; d < HEXDIGITS; d++) begin : g_hex
    seven_seg_decoder u_dec (.i_nib(r_hex[4*d +: 4]), .o_seg(HEX[7*d +: 7]));
  end
endmodule

// File: tb/tb_ui_device_controller.sv
// tb_ui_device_controller: randomized checks of ui_device_controller against a pin-history reference model.
module tb_ui_device_controller;
  import ui_device_controller_pkg::*;
  localparam int KB = 4, SB = 10, NB = 14, DB = 16;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  uiDevice = 2'd0;
  logic        uiWrtEn = 1'b0, uiRdEn = 1'b0;
  logic [31:0] dataIn = '0, dataOut;
  logic [KB-1:0] KEY = '1;
  logic [SB-1:0] SW = '0;
  logic [9:0]  LEDR;
  logic [27:0] HEX;
  int n_checks = 0, n_fail = 0;

  ui_device_controller dut (.clk(clk), .reset_n(reset_n), .uiDevice(uiDevice), .uiWrtEn(uiWrtEn),
    .uiRdEn(uiRdEn), .dataIn(dataIn), .dataOut(dataOut), .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX));

  always #5 clk = ~clk;

  // Reference: a pin flips its accepted level once its last DB synchronised samples all disagree with it
  logic [NB-1:0] hist [0:DB];
  logic [NB-1:0] m_deb, m_flip;
  logic [KB-1:0] m_pend, m_clr;
  logic [15:0]   m_hex;
  logic [9:0]    m_led;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= DB; j++) hist[j] = '0;
      m_deb = '0; m_pend = '0; m_hex = '0; m_led = '0;
    end else begin
      m_flip = '1;
      for (int j = 1; j <= DB; j++) m_flip &= hist[j] ^ m_deb;
      m_clr = ((uiRdEn && uiDevice == UI_KEY) ? 4'hF : 4'h0) |
              ((uiWrtEn && uiDevice == UI_KEY) ? dataIn[3:0] : 4'h0);
      m_pend = (m_pend & ~m_clr) | (m_flip[KB-1:0] & ~m_deb[KB-1:0]);
      m_deb = m_deb ^ m_flip;
      if (uiWrtEn && uiDevice == UI_HEX) m_hex = dataIn[15:0];
      if (uiWrtEn && uiDevice == UI_LEDR) m_led = dataIn[9:0];
      for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {SW, ~KEY};
    end
  end

  function automatic logic [31:0] exp_read(input logic [1:0] d);
`ifdef UI_KEY_STICKY_EN
    logic [3:0] k = m_pend;
`else
    logic [3:0] k = m_deb[KB-1:0];
`endif
    return d == UI_HEX ? {16'h0, m_hex} : d == UI_LEDR ? {22'h0, m_led} :
           d == UI_KEY ? {28'h0, k} : {22'h0, m_deb[NB-1:KB]};
  endfunction

  function automatic logic [27:0] exp_hex();
    logic [27:0] h;
    for (int d = 0; d < 4; d++) h[7*d +: 7] = SEG[m_hex[4*d +: 4]];
    return h;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; KEY = '1; SW = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (HEX !== {4{7'b1000000}}) begin n_fail++; $display("FAIL reset_hex got=%h exp=%h", HEX, {4{7'b1000000}}); end
    n_checks++; if (LEDR !== 10'h0) begin n_fail++; $display("FAIL reset_ledr got=%h exp=0", LEDR); end
    reset_n = 1'b1;
    @(negedge clk);
    uiDevice = UI_KEY; #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_key got=%h exp=0", dataOut); end
    uiDevice = UI_SW; #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_sw got=%h exp=0", dataOut); end
    uiDevice = UI_HEX; #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_hexrd got=%h exp=0", dataOut); end
  endtask

  task automatic test_write();
    logic [31:0] old;
    @(negedge clk);
    uiDevice = UI_HEX; uiWrtEn = 1'b1; dataIn = 32'h0000BEEF;
    @(negedge clk); uiWrtEn = 1'b0; #1;
    n_checks++; if (dataOut !== 32'hBEEF) begin n_fail++; $display("FAIL hex_read got=%h exp=0000beef", dataOut); end
    n_checks++; if (HEX[6:0] !== 7'b0001110) begin n_fail++; $display("FAIL hex_digit0 got=%b exp=0001110", HEX[6:0]); end
    n_checks++; if (HEX !== exp_hex()) begin n_fail++; $display("FAIL hex_pins got=%h exp=%h", HEX, exp_hex()); end
    @(negedge clk);
    uiDevice = UI_LEDR; uiWrtEn = 1'b1; dataIn = 32'hFFFFFFFF;
    @(negedge clk); uiWrtEn = 1'b0; #1;
    n_checks++; if (LEDR !== 10'h3FF) begin n_fail++; $display("FAIL ledr_pins got=%h exp=3ff", LEDR); end
    n_checks++; if (dataOut !== 32'h3FF) begin n_fail++; $display("FAIL ledr_read got=%h exp=3ff", dataOut); end
    @(negedge clk);
    uiDevice = UI_SW; uiWrtEn = 1'b1; dataIn = 32'hFFFFFFFF;
    @(negedge clk); uiWrtEn = 1'b0; #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL sw_write_ignored got=%h exp=0", dataOut); end
    // Simultaneous write and read returns the pre-write value
    uiDevice = UI_HEX; uiWrtEn = 1'b1; uiRdEn = 1'b1; dataIn = 32'h00001234; old = exp_read(UI_HEX); #1;
    n_checks++; if (dataOut !== old) begin n_fail++; $display("FAIL wr_rd_old got=%h exp=%h", dataOut, old); end
    @(negedge clk); uiWrtEn = 1'b0; uiRdEn = 1'b0; #1;
    n_checks++; if (dataOut !== 32'h1234) begin n_fail++; $display("FAIL wr_rd_new got=%h exp=00001234", dataOut); end
    for (int i = 0; i < 12; i++) begin
      uiDevice = 2'($urandom); uiWrtEn = 1'b1; dataIn = $urandom;
      @(negedge clk); uiWrtEn = 1'b0; uiDevice = 2'($urandom); #1;
      n_checks++; if (dataOut !== exp_read(uiDevice)) begin n_fail++; $display("FAIL rand_write dev=%0d got=%h exp=%h", uiDevice, dataOut, exp_read(uiDevice)); end
      n_checks++; if (HEX !== exp_hex() || LEDR !== m_led) begin n_fail++; $display("FAIL rand_pins hex=%h/%h ledr=%h/%h", HEX, exp_hex(), LEDR, m_led); end
    end
  endtask

  task automatic test_sw_debounce();
    int c;
    uiDevice = UI_SW; SW = 10'h008;
    for (int i = 0; i < 15; i++) @(negedge clk);
    SW = 10'h000;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL sw_glitch cyc=%0d got=%h exp=0", i, dataOut); end
    end
    SW = 10'h008;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (dataOut === 32'h8) break;
    end
    n_checks++; if (c != 2 + DB) begin n_fail++; $display("FAIL sw_latency got=%0d exp=%0d", c, 2 + DB); end
    n_checks++; if (dataOut !== exp_read(UI_SW)) begin n_fail++; $display("FAIL sw_model got=%h exp=%h", dataOut, exp_read(UI_SW)); end
  endtask

  task automatic test_key();
    uiDevice = UI_KEY; uiRdEn = 1'b1;
    @(negedge clk); uiRdEn = 1'b0;
`ifdef UI_KEY_STICKY_EN
    KEY = 4'hE; repeat (20) @(negedge clk);
    KEY = 4'hF; repeat (20) @(negedge clk);
    uiRdEn = 1'b1; #1;
    n_checks++; if (dataOut !== 32'h1) begin n_fail++; $display("FAIL sticky_first got=%h exp=1", dataOut); end
    @(negedge clk); #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL sticky_second got=%h exp=0", dataOut); end
    uiRdEn = 1'b0;
    // Press accepted on edge 2+DB; hold a read strobe across exactly that edge
    KEY = 4'hD; repeat (2 + DB - 1) @(negedge clk);
    uiRdEn = 1'b1;
    @(negedge clk); uiRdEn = 1'b0; #1;
    n_checks++; if (dataOut !== 32'h2) begin n_fail++; $display("FAIL sticky_set_wins got=%h exp=2", dataOut); end
    n_checks++; if (dataOut !== exp_read(UI_KEY)) begin n_fail++; $display("FAIL sticky_model got=%h exp=%h", dataOut, exp_read(UI_KEY)); end
    KEY = 4'hF; repeat (20) @(negedge clk);
    uiWrtEn = 1'b1; dataIn = 32'h2;
    @(negedge clk); uiWrtEn = 1'b0; #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL sticky_w1c got=%h exp=0", dataOut); end
`else
    KEY = 4'hB; repeat (20) @(negedge clk); #1;
    n_checks++; if (dataOut !== 32'h4) begin n_fail++; $display("FAIL key_held got=%h exp=4", dataOut); end
    KEY = 4'hF; repeat (20) @(negedge clk); #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL key_released got=%h exp=0", dataOut); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(23) == 0) KEY[$urandom_range(KB-1)] ^= 1'b1;
      if ($urandom_range(23) == 0) SW[$urandom_range(SB-1)] ^= 1'b1;
      uiDevice = 2'($urandom); uiWrtEn = ($urandom_range(3) == 0); uiRdEn = ($urandom_range(2) == 0);
      dataIn = $urandom; #1;
      n_checks++; if (dataOut !== exp_read(uiDevice)) begin n_fail++; $display("FAIL random cyc=%0d dev=%0d got=%h exp=%h", i, uiDevice, dataOut, exp_read(uiDevice)); end
      if (i % 16 == 0) begin
        n_checks++; if (HEX !== exp_hex() || LEDR !== m_led) begin n_fail++; $display("FAIL random_pins hex=%h/%h ledr=%h/%h", HEX, exp_hex(), LEDR, m_led); end
      end
    end
    @(negedge clk); uiWrtEn = 1'b0; uiRdEn = 1'b0;
  endtask

  task automatic test_async_reset();
    int c;
    KEY = 4'hF;
    uiDevice = UI_HEX; uiWrtEn = 1'b1; dataIn = 32'h0000A5C3;
    @(negedge clk); uiDevice = UI_LEDR; dataIn = 32'h155;
    @(negedge clk); uiWrtEn = 1'b0; SW = 10'h200;
    repeat (8) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b0; #1;
    n_checks++; if (HEX !== {4{7'b1000000}}) begin n_fail++; $display("FAIL async_hex got=%h exp=%h", HEX, {4{7'b1000000}}); end
    n_checks++; if (LEDR !== 10'h0) begin n_fail++; $display("FAIL async_ledr got=%h exp=0", LEDR); end
    uiDevice = UI_HEX; #1;
    n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL async_hexrd got=%h exp=0", dataOut); end
    @(negedge clk); reset_n = 1'b1; uiDevice = UI_SW;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (dataOut === 32'h200) break;
    end
    n_checks++; if (c != 2 + DB) begin n_fail++; $display("FAIL async_sw_latency got=%0d exp=%0d", c, 2 + DB); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_sw_debounce();
    test_key();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
